// File: rtl/instruction_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
package instruction_fetch_unit_pkg;

    typedef enum logic [0:0] {
        StRun,
        StDrain
    } fetch_state_e;

    localparam logic [31:0] InstrNop = 32'h0000_0013;

endpackage

// File: rtl/instruction_fetch_unit_fifo.sv
// Small synchronous FIFO with flush and occupancy count; used for both the
// decode-facing output buffer and the in-order queue of pending fetch PCs.
module instruction_fetch_unit_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 64
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  rd_ptr_q;
    logic [PtrW-1:0]  wr_ptr_q;
    logic [CntW-1:0]  count_q;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
        return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign do_push = push && (count_q != CntW'(DEPTH));
    assign do_pop  = pop && (count_q != '0);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata;
                wr_ptr_q        <= next_ptr(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= next_ptr(rd_ptr_q);
            end
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// IF stage: issues the current PC to instruction memory, buffers returned words
// with their PC and hands them to decode; redirects flush and drain stale fetches.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc_in,
    output logic              pc_advance,
    input  logic              redirect,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [DATA_W-1:0] id_instr,
    output logic [ADDR_W-1:0] id_pc
);

    localparam int unsigned CntW = $clog2(DEPTH + 1);

    fetch_state_e    state_q, state_d;
    logic            started_q;
    logic [CntW-1:0] outstanding_q, outstanding_d;
    logic [CntW-1:0] drop_q, drop_d;
    logic [CntW-1:0] out_count;
    logic [CntW-1:0] tag_count;
    logic [ADDR_W-1:0] tag_pc;
    logic            run;
    logic            credit;
    logic            issue;
    logic            rvalid_ok;
    logic            resp;
    logic            pop;

    assign run       = (state_q == StRun);
    assign credit    = ({1'b0, outstanding_q} + {1'b0, out_count}) < (CntW + 1)'(DEPTH);
    assign imem_req  = started_q && run && credit && !redirect;
    assign imem_addr = {pc_in[ADDR_W-1:2], 2'b00};
    assign issue     = imem_req && imem_gnt;
    assign pc_advance = issue;

    // A response with nothing outstanding is a protocol error and is ignored.
    assign rvalid_ok = imem_rvalid && (outstanding_q != '0);
    assign resp      = rvalid_ok && run && !redirect;

    assign id_valid = (out_count != '0);
    assign pop      = id_valid && id_ready && !redirect;

    instruction_fetch_unit_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ADDR_W)
    ) u_tag_queue (
        .clock (clock),
        .reset (reset),
        .flush (redirect),
        .push  (issue),
        .wdata (pc_in),
        .pop   (resp),
        .rdata (tag_pc),
        .count (tag_count)
    );

    instruction_fetch_unit_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ADDR_W + DATA_W)
    ) u_out_fifo (
        .clock (clock),
        .reset (reset),
        .flush (redirect),
        .push  (resp),
        .wdata ({tag_pc, imem_rdata}),
        .pop   (pop),
        .rdata ({id_pc, id_instr}),
        .count (out_count)
    );

    always_comb begin
        state_d       = state_q;
        outstanding_d = outstanding_q;
        drop_d        = drop_q;
        if (redirect) begin
            // Everything still in flight becomes a drop, minus a response landing now.
            outstanding_d = outstanding_q - CntW'(rvalid_ok);
            drop_d        = outstanding_d;
            state_d       = (outstanding_d != '0) ? StDrain : StRun;
        end else if (state_q == StDrain) begin
            if (rvalid_ok) begin
                outstanding_d = outstanding_q - CntW'(1);
                drop_d        = drop_q - CntW'(1);
                if (drop_q == CntW'(1)) begin
                    state_d = StRun;
                end
            end
        end else begin
            unique case ({issue, resp})
                2'b10:   outstanding_d = outstanding_q + CntW'(1);
                2'b01:   outstanding_d = outstanding_q - CntW'(1);
                default: outstanding_d = outstanding_q;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= StRun;
            started_q     <= 1'b0;
            outstanding_q <= '0;
            drop_q        <= '0;
        end else begin
            state_q       <= state_d;
            started_q     <= 1'b1;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
        end
    end

    rvalid_expected_a : assert property (@(posedge clock) disable iff (!reset)
        imem_rvalid |-> (outstanding_q != '0));

    tag_tracks_outstanding_a : assert property (@(posedge clock) disable iff (!reset)
        (state_q == StRun) |-> (tag_count == outstanding_q));

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a PC model and an in-order
// instruction memory model whose responses can be held back.
module tb_instruction_fetch_unit;

    localparam logic [31:0] DataKey = 32'h5a5a_0000;

    logic        clock;
    logic        reset;
    logic [31:0] pc_in;
    logic        pc_advance;
    logic        redirect;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;

    int          total;
    int          bad;
    logic [31:0] mq [$];
    logic        hold;
    logic [31:0] target;
    logic        watch;
    logic        stale_seen;

    instruction_fetch_unit #(
        .DEPTH  (2),
        .ADDR_W (32),
        .DATA_W (32)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .pc_in       (pc_in),
        .pc_advance  (pc_advance),
        .redirect    (redirect),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .id_valid    (id_valid),
        .id_ready    (id_ready),
        .id_instr    (id_instr),
        .id_pc       (id_pc)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic mem_drive();
        if (!hold && mq.size() > 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mq[0] ^ DataKey;
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = '0;
        end
    endtask

    // One clock: sample handshakes before the edge, update PC/memory after it.
    task automatic cycle();
        logic        iss;
        logic        rv;
        logic [31:0] a;
        #1;
        iss = imem_req & imem_gnt;
        rv  = imem_rvalid;
        a   = imem_addr;
        @(posedge clock);
        #1;
        if (rv && mq.size() > 0) void'(mq.pop_front());
        if (iss) mq.push_back(a);
        if (redirect) pc_in = target;
        else if (iss) pc_in = pc_in + 32'd4;
        redirect = 1'b0;
        mem_drive();
        #1;
        if (watch && id_valid && (id_pc == 32'h20 || id_pc == 32'h24)) stale_seen = 1'b1;
    endtask

    task automatic do_reset(input logic [31:0] pc);
        reset = 1'b0;
        #1;
        mq.delete();
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        redirect    = 1'b0;
        pc_in       = pc;
        @(posedge clock);
        #3;
        reset = 1'b1;
        #1;
        cycle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        total = 0; bad = 0;
        reset = 1'b0; pc_in = '0; redirect = 1'b0; imem_gnt = 1'b1;
        imem_rvalid = 1'b0; imem_rdata = '0; id_ready = 1'b1;
        hold = 1'b0; target = '0; watch = 1'b0; stale_seen = 1'b0;

        // 1: reset values, then streaming with a 1-cycle memory
        #3;
        chk("rst_req", 32'(imem_req), 0);
        chk("rst_adv", 32'(pc_advance), 0);
        chk("rst_valid", 32'(id_valid), 0);
        chk("rst_pc", id_pc, 0);
        chk("rst_instr", id_instr, 0);
        @(posedge clock);
        #3;
        reset = 1'b1;
        #1;
        chk("t1_req_before_start", 32'(imem_req), 0);
        cycle();
        chk("t1_req0", 32'(imem_req), 1);
        chk("t1_addr0", imem_addr, 32'h0);
        chk("t1_adv0", 32'(pc_advance), 1);
        cycle();
        chk("t1_novalid_yet", 32'(id_valid), 0);
        chk("t1_addr4", imem_addr, 32'h4);
        chk("t1_adv4", 32'(pc_advance), 1);
        cycle();
        chk("t1_valid0", 32'(id_valid), 1);
        chk("t1_idpc0", id_pc, 32'h0);
        chk("t1_instr0", id_instr, 32'h0 ^ DataKey);
        chk("t1_credit_stall", 32'(pc_advance), 0);
        cycle();
        chk("t1_idpc4", id_pc, 32'h4);
        chk("t1_addr8", imem_addr, 32'h8);
        chk("t1_adv8", 32'(pc_advance), 1);
        cycle();
        chk("t1_bubble", 32'(id_valid), 0);
        cycle();
        chk("t1_idpc8", id_pc, 32'h8);
        chk("t1_instr8", id_instr, 32'h8 ^ DataKey);

        // 2: decode stalled, only DEPTH fetches in flight/buffered
        id_ready = 1'b0;
        do_reset(32'h0);
        cycle();
        cycle();
        chk("t2_req_off", 32'(imem_req), 0);
        chk("t2_head0", id_pc, 32'h0);
        cycle();
        cycle();
        chk("t2_still_off", 32'(imem_req), 0);
        chk("t2_still_head0", id_pc, 32'h0);
        id_ready = 1'b1;
        cycle();
        chk("t2_head4", id_pc, 32'h4);
        chk("t2_resume_addr", imem_addr, 32'h8);
        chk("t2_resume_adv", 32'(pc_advance), 1);
        cycle();
        chk("t2_empty", 32'(id_valid), 0);

        // 3: grant withheld
        imem_gnt = 1'b0;
        do_reset(32'h10);
        chk("t3_req", 32'(imem_req), 1);
        chk("t3_adv_a", 32'(pc_advance), 0);
        cycle();
        chk("t3_addr_b", imem_addr, 32'h10);
        chk("t3_adv_b", 32'(pc_advance), 0);
        cycle();
        chk("t3_addr_c", imem_addr, 32'h10);
        chk("t3_adv_c", 32'(pc_advance), 0);
        imem_gnt = 1'b1;
        #1;
        chk("t3_adv_gnt", 32'(pc_advance), 1);
        chk("t3_addr_gnt", imem_addr, 32'h10);
        cycle();
        chk("t3_next_addr", imem_addr, 32'h14);
        cycle();
        chk("t3_idpc", id_pc, 32'h10);
        chk("t3_instr", id_instr, 32'h10 ^ DataKey);

        // 4: redirect with two fetches outstanding
        hold = 1'b1;
        do_reset(32'h20);
        watch = 1'b1;
        stale_seen = 1'b0;
        cycle();
        cycle();
        chk("t4_full_credit", 32'(imem_req), 0);
        target = 32'h100;
        redirect = 1'b1;
        #1;
        chk("t4_redir_adv", 32'(pc_advance), 0);
        cycle();
        chk("t4_drain_req", 32'(imem_req), 0);
        hold = 1'b0;
        mem_drive();
        #1;
        cycle();
        chk("t4_drain_req2", 32'(imem_req), 0);
        chk("t4_drain_valid", 32'(id_valid), 0);
        cycle();
        chk("t4_run_req", 32'(imem_req), 1);
        chk("t4_run_addr", imem_addr, 32'h100);
        cycle();
        cycle();
        chk("t4_idpc", id_pc, 32'h100);
        chk("t4_instr", id_instr, 32'h100 ^ DataKey);
        watch = 1'b0;
        chk("t4_no_stale", 32'(stale_seen), 0);

        // 5: redirect coincident with the only response
        do_reset(32'h40);
        cycle();
        chk("t5_rvalid_up", 32'(imem_rvalid), 1);
        target = 32'h180;
        redirect = 1'b1;
        #1;
        chk("t5_redir_req", 32'(imem_req), 0);
        cycle();
        chk("t5_valid", 32'(id_valid), 0);
        chk("t5_req", 32'(imem_req), 1);
        chk("t5_addr", imem_addr, 32'h180);
        cycle();
        cycle();
        chk("t5_idpc", id_pc, 32'h180);

        // 6: asynchronous reset with a full buffer, then mid-drain
        id_ready = 1'b0;
        do_reset(32'h60);
        cycle();
        cycle();
        cycle();
        chk("t6_full_valid", 32'(id_valid), 1);
        chk("t6_full_head", id_pc, 32'h60);
        #2;
        reset = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(id_valid), 0);
        chk("t6_rst_req", 32'(imem_req), 0);
        chk("t6_rst_pc", id_pc, 32'h0);
        id_ready = 1'b1;
        hold = 1'b1;
        do_reset(32'h80);
        cycle();
        cycle();
        target = 32'h200;
        redirect = 1'b1;
        cycle();
        chk("t6_drain_req", 32'(imem_req), 0);
        #2;
        reset = 1'b0;
        #1;
        chk("t6_rst2_req", 32'(imem_req), 0);
        chk("t6_rst2_valid", 32'(id_valid), 0);
        chk("t6_rst2_adv", 32'(pc_advance), 0);
        hold = 1'b0;
        do_reset(32'h300);
        chk("t6_restart_addr", imem_addr, 32'h300);
        chk("t6_restart_req", 32'(imem_req), 1);
        cycle();
        cycle();
        chk("t6_restart_idpc", id_pc, 32'h300);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
